// File: rtl/keypad_display_ctrl.sv
// 4x4 hex keypad scanner with tick-based debounce, an NDIGITS-deep key buffer,
// and a time-multiplexed common-anode seven-segment display driver.
module keypad_display_ctrl #(
  parameter int NDIGITS  = 4,
  parameter int SCANBITS = 3,
  parameter int DEBOUNCE = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [3:0]           rows,
  output wire  [3:0]           cols,
  input  logic                 sel_switch,
  input  logic [4*NDIGITS-1:0] switches,
  input  logic                 clear,
  output logic                 key_valid,
  output logic [3:0]           key_code,
  output logic [6:0]           sevenSeg,
  output logic [NDIGITS-1:0]   enables
);

  localparam int RW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

  typedef enum logic [1:0] {
    ST_SCAN,
    ST_DEBOUNCE,
    ST_HELD
  } state_t;

  state_t              state_q, state_d;
  logic [SCANBITS-1:0] presc_q;
  logic                tick;
  logic [1:0]          col_q, col_d;
  logic [1:0]          row_q, row_d;
  logic [3:0]          cnt_q, cnt_d;
  logic [3:0]          row_mask;
  logic                accept;
  logic [3:0]          new_code;
  logic                key_valid_q;
  logic [3:0]          key_code_q;
  logic [3:0]          digit_q [NDIGITS];
  logic [RW-1:0]       r_q, r_d;
  logic [3:0]          disp_nib;

  function automatic logic [1:0] top_row(input logic [3:0] r);
    logic [1:0] idx;
    if (r[3])      idx = 2'd3;
    else if (r[2]) idx = 2'd2;
    else if (r[1]) idx = 2'd1;
    else           idx = 2'd0;
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] v;
    case ({col, row})
      4'b00_11: v = 4'h1;
      4'b00_10: v = 4'h4;
      4'b00_01: v = 4'h7;
      4'b00_00: v = 4'hE;
      4'b01_11: v = 4'h2;
      4'b01_10: v = 4'h5;
      4'b01_01: v = 4'h8;
      4'b01_00: v = 4'h0;
      4'b10_11: v = 4'h3;
      4'b10_10: v = 4'h6;
      4'b10_01: v = 4'h9;
      4'b10_00: v = 4'hF;
      4'b11_11: v = 4'hA;
      4'b11_10: v = 4'hB;
      4'b11_01: v = 4'hC;
      default:  v = 4'hD;
    endcase
    return v;
  endfunction

  // Segment order gfedcba, active-low (common anode).
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0:    s = 7'b1000000;
      4'h1:    s = 7'b1111001;
      4'h2:    s = 7'b0100100;
      4'h3:    s = 7'b0110000;
      4'h4:    s = 7'b0011001;
      4'h5:    s = 7'b0010010;
      4'h6:    s = 7'b0000010;
      4'h7:    s = 7'b1111000;
      4'h8:    s = 7'b0000000;
      4'h9:    s = 7'b0011000;
      4'hA:    s = 7'b0001000;
      4'hB:    s = 7'b0000011;
      4'hC:    s = 7'b0100111;
      4'hD:    s = 7'b0100001;
      4'hE:    s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of every other flop, independent of block ordering.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + SCANBITS'(1);
    end
  end

  assign tick     = &presc_q;
  assign row_mask = 4'b0001 << row_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case statement leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    cnt_d    = cnt_q;
    accept   = 1'b0;
    new_code = key_map(row_q, col_q);
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (rows == 4'b0000) begin
            col_d = col_q + 2'd1;
          end else begin
            row_d = top_row(rows);
            cnt_d = 4'd1;
            if (DEBOUNCE == 1) begin
              accept   = 1'b1;
              new_code = key_map(top_row(rows), col_q);
              state_d  = ST_HELD;
            end else begin
              state_d = ST_DEBOUNCE;
            end
          end
        end
        ST_DEBOUNCE: begin
          if ((rows & row_mask) == 4'b0000) begin
            state_d = ST_SCAN;
          end else begin
            cnt_d = cnt_q + 4'd1;
            if (cnt_d == 4'(DEBOUNCE)) begin
              accept  = 1'b1;
              state_d = ST_HELD;
            end
          end
        end
        ST_HELD: begin
          // Other keys are ignored; only the release of the accepted row matters.
          if ((rows & row_mask) == 4'b0000) state_d = ST_SCAN;
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      row_q       <= 2'd0;
      cnt_q       <= 4'd0;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'h0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      cnt_q       <= cnt_d;
      key_valid_q <= accept;
      if (accept) key_code_q <= new_code;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the buffer is shown on the display straight out of reset, so it
      // is cleared like any other state instead of being left uninitialised.
      for (int i = 0; i < NDIGITS; i++) digit_q[i] <= 4'h0;
    end else if (clear) begin
      for (int i = 0; i < NDIGITS; i++) digit_q[i] <= 4'h0;
    end else if (accept) begin
      for (int i = NDIGITS - 1; i > 0; i--) digit_q[i] <= digit_q[i-1];
      digit_q[0] <= new_code;
    end
  end

  always_comb begin
    r_d = r_q;
    if (tick) r_d = (r_q == RW'(NDIGITS - 1)) ? '0 : r_q + RW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_q <= '0;
    end else begin
      r_q <= r_d;
    end
  end

  always_comb begin
    enables      = '0;
    enables[r_q] = 1'b1;
    disp_nib     = sel_switch ? switches[{r_q, 2'b00} +: 4] : digit_q[r_q];
    sevenSeg     = seg_decode(disp_nib);
  end

  // Column 0 is the MSB of the bus; undriven columns float.
  for (genvar c = 0; c < 4; c++) begin : g_cols
    assign cols[3-c] = (col_q == 2'(c)) ? 1'b1 : 1'bz;
  end

  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: tb/tb_keypad_display_ctrl.sv
// Self-checking bench: a tick-level behavioural model of the keypad/display
// is compared against the DUT every clock, plus directed literal checks.
module tb_keypad_display_ctrl;

  localparam int NDIGITS  = 4;
  localparam int SCANBITS = 3;
  localparam int DEBOUNCE = 2;
  localparam int TICKLEN  = 1 << SCANBITS;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic [3:0]           rows = 4'h0;
  wire  [3:0]           cols;
  logic                 sel_switch = 1'b0;
  logic [4*NDIGITS-1:0] switches = '0;
  logic                 clear = 1'b0;
  logic                 key_valid;
  logic [3:0]           key_code;
  logic [6:0]           sevenSeg;
  logic [NDIGITS-1:0]   enables;

  int n_checks = 0;
  int n_fail   = 0;
  int kv_count = 0;
  bit cmp_en   = 1'b0;

  always #5 clk = ~clk;

  keypad_display_ctrl #(
    .NDIGITS (NDIGITS),
    .SCANBITS(SCANBITS),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rows      (rows),
    .cols      (cols),
    .sel_switch(sel_switch),
    .switches  (switches),
    .clear     (clear),
    .key_valid (key_valid),
    .key_code  (key_code),
    .sevenSeg  (sevenSeg),
    .enables   (enables)
  );

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0011000, 7'b0001000, 7'b0000011,
    7'b0100111, 7'b0100001, 7'b0000110, 7'b0001110
  };

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Key value from keypad position: three numeric rows, then the bottom row
  // (E,0,F) and the letter column (A..D top to bottom).
  function automatic int key_value(input int row, input int col);
    if (col == 3) return 10 + (3 - row);
    if (row == 0) return (col == 0) ? 14 : (col == 1) ? 0 : 15;
    return (3 - row) * 3 + col + 1;
  endfunction

  // Behavioural model, advanced once per clock.
  int m_presc, m_col, m_row, m_seen, m_r, m_kc;
  bit m_held, m_kv;
  int m_dig[$];

  task automatic model_reset();
    m_presc = 0; m_col = 0; m_row = 0; m_seen = 0; m_r = 0; m_kc = 0;
    m_held = 1'b0; m_kv = 1'b0;
    m_dig.delete();
    for (int i = 0; i < NDIGITS; i++) m_dig.push_back(0);
  endtask

  initial model_reset();

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      model_reset();
    end else begin : step
      bit tick;
      bit acc;
      tick    = (m_presc == TICKLEN - 1);
      m_presc = (m_presc + 1) % TICKLEN;
      m_kv    = 1'b0;
      acc     = 1'b0;
      if (tick) begin
        m_r = (m_r + 1) % NDIGITS;
        if (m_held) begin
          if (!rows[m_row]) m_held = 1'b0;
        end else if (m_seen > 0) begin
          if (!rows[m_row]) m_seen = 0;
          else begin
            m_seen++;
            if (m_seen >= DEBOUNCE) begin acc = 1'b1; m_seen = 0; m_held = 1'b1; end
          end
        end else if (rows != 4'h0) begin
          for (int b = 0; b < 4; b++) if (rows[b]) m_row = b;
          m_seen = 1;
          if (DEBOUNCE == 1) begin acc = 1'b1; m_seen = 0; m_held = 1'b1; end
        end else begin
          m_col = (m_col + 1) % 4;
        end
      end
      if (acc) begin
        m_kv = 1'b1;
        m_kc = key_value(m_row, m_col);
        m_dig.push_front(m_kc);
        void'(m_dig.pop_back());
      end
      if (clear) foreach (m_dig[i]) m_dig[i] = 0;
    end
  end

  logic [3:0] cols_hi;
  int         exp_nib;

  always @(posedge clk) begin
    #1;
    if (cmp_en) begin
      for (int i = 0; i < 4; i++) cols_hi[i] = (cols[i] === 1'b1);
      exp_nib = sel_switch ? int'((switches >> (4 * m_r)) & 'hF) : m_dig[m_r];
      check("cols", cols_hi, 4'b1000 >> m_col);
      check("enables", enables, 1 << m_r);
      check("sevenSeg", sevenSeg, seg_tab[exp_nib]);
      check("key_valid", key_valid, m_kv);
      check("key_code", key_code, m_kc);
      if (key_valid === 1'b1) kv_count++;
    end
  end

  task automatic wait_ticks(input int n);
    repeat (n * TICKLEN) @(negedge clk);
  endtask

  // Wait until the scanner is idle and has just moved onto column c.
  task automatic wait_scan_col(input int c, input string name);
    bit found = 1'b0;
    for (int k = 0; k < 20 * TICKLEN; k++) begin
      @(negedge clk);
      if (!m_held && m_seen == 0 && m_col == c && m_presc == 0) begin
        found = 1'b1;
        break;
      end
    end
    check({name, "_wait"}, found, 1);
  endtask

  task automatic press(input int c, input logic [3:0] r, input int hold_ticks);
    wait_scan_col(c, "press");
    rows = r;
    wait_ticks(hold_ticks);
    rows = 4'h0;
    wait_ticks(2);
  endtask

  task automatic check_digits(input logic [6:0] exp [NDIGITS], input string name);
    bit found = 1'b0;
    sel_switch = 1'b0;
    for (int k = 0; k < 4 * TICKLEN * NDIGITS; k++) begin
      @(negedge clk);
      if (m_r == 0) begin found = 1'b1; break; end
    end
    check({name, "_sync"}, found, 1);
    for (int i = 0; i < NDIGITS; i++) begin
      check({name, "_seg"}, sevenSeg, exp[i]);
      check({name, "_en"}, enables, 1 << i);
      repeat (TICKLEN) @(negedge clk);
    end
  endtask

  int         kv0;
  logic [6:0] exp_d [NDIGITS];

  initial begin
    #1 reset = 1'b0;
    #1 cmp_en = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Single press: key 5, key_valid exactly 16 clocks after rows appear.
    kv0 = kv_count;
    wait_scan_col(1, "single");
    rows = 4'b0100;
    repeat (15) @(negedge clk);
    check("single_early", key_valid, 1'b0);
    @(negedge clk);
    check("single_latency", key_valid, 1'b1);
    wait_ticks(3);
    rows = 4'h0;
    wait_ticks(2);
    check("single_count", kv_count - kv0, 1);
    check("single_code", key_code, 4'h5);

    // Bounce: exactly one tick sees the row.
    kv0 = kv_count;
    wait_scan_col(2, "bounce");
    rows = 4'b0010;
    repeat (TICKLEN) @(negedge clk);
    rows = 4'h0;
    wait_ticks(4);
    check("bounce_count", kv_count - kv0, 0);

    // Reset mid-debounce: immediate reset values, press discarded.
    kv0 = kv_count;
    wait_scan_col(1, "rst");
    rows = 4'b0001;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_col0", cols[3] === 1'b1, 1);
    check("rst_cols_other", {cols[2] === 1'b1, cols[1] === 1'b1, cols[0] === 1'b1}, 3'b000);
    check("rst_enables", enables, 4'b0001);
    check("rst_seg", sevenSeg, 7'b1000000);
    check("rst_kv", key_valid, 1'b0);
    check("rst_code", key_code, 4'h0);
    repeat (2) @(negedge clk);
    rows = 4'h0;
    @(negedge clk);
    reset = 1'b1;
    wait_ticks(4);
    check("rst_discard", kv_count - kv0, 0);

    // Hold then sequence: 1 (held 20 ticks), A, B, C, D.
    kv0 = kv_count;
    press(0, 4'b1000, 20);
    press(3, 4'b1000, 3);
    press(3, 4'b0100, 3);
    press(3, 4'b0010, 3);
    press(3, 4'b0001, 3);
    check("seq_count", kv_count - kv0, 5);
    exp_d = '{7'b0100001, 7'b0100111, 7'b0000011, 7'b0001000};
    check_digits(exp_d, "seq_buf");

    // Multi-row at column 0: top row wins.
    kv0 = kv_count;
    press(0, 4'b1001, 3);
    check("multi_count", kv_count - kv0, 1);
    check("multi_code", key_code, 4'h1);

    // Buffer 1,2,3,4 then switch mode.
    press(0, 4'b1000, 2);
    press(1, 4'b1000, 2);
    press(2, 4'b1000, 2);
    press(0, 4'b0100, 2);
    exp_d = '{7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001};
    check_digits(exp_d, "buf1234");
    switches = 16'h9876;
    @(negedge clk);
    sel_switch = 1'b1;
    #1;
    for (int k = 0; k < 4 * TICKLEN * NDIGITS && m_r != 0; k++) @(negedge clk);
    exp_d = '{7'b0000010, 7'b1111000, 7'b0000000, 7'b0011000};
    for (int i = 0; i < NDIGITS; i++) begin
      check("sw_seg", sevenSeg, exp_d[i]);
      check("sw_en", enables, 1 << i);
      repeat (TICKLEN) @(negedge clk);
    end
    sel_switch = 1'b0;

    // Clear coinciding with an accept: key_code updates, buffer ends all zero.
    kv0 = kv_count;
    wait_scan_col(1, "clr");
    rows = 4'b1000;
    begin : clr_sync
      bit found = 1'b0;
      for (int k = 0; k < 4 * TICKLEN; k++) begin
        if (m_seen == DEBOUNCE - 1 && m_presc == TICKLEN - 1) begin found = 1'b1; break; end
        @(negedge clk);
      end
      check("clr_sync", found, 1);
    end
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    wait_ticks(2);
    rows = 4'h0;
    wait_ticks(2);
    check("clr_count", kv_count - kv0, 1);
    check("clr_code", key_code, 4'h2);
    exp_d = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1000000};
    check_digits(exp_d, "clr_buf");

    // Randomised traffic, checked by the model every clock.
    for (int it = 0; it < 150; it++) begin
      int hold;
      if ($urandom_range(0, 7) == 0) sel_switch = ~sel_switch;
      if ($urandom_range(0, 7) == 0) switches = 16'($urandom);
      rows = ($urandom_range(0, 1) != 0) ? 4'($urandom_range(1, 15)) : 4'h0;
      hold = $urandom_range(1, 48);
      if ($urandom_range(0, 19) == 0) begin
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
      end
      repeat (hold) @(negedge clk);
    end
    rows = 4'h0;
    wait_ticks(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
